// File: rtl/branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared definitions for the branch control block and its predictor table:
//   - funct3 encodings of the conditional branches
//   - FSM state enum (RUN / SHADOW)
//   - predictor counter reset value (weakly not-taken)
//   - helper that resolves a conditional branch direction from the comparator
// ---------------------------------------------------------------------------
package branch_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CTR_RESET = 2'b01;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_e;

  // Direction of a conditional branch; undefined encodings (010/011)
  // resolve as not taken.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic       less,
                                        input logic       equal);
    logic t;
    case (funct3)
      F3_BEQ:            t = equal;
      F3_BNE:            t = !equal;
      F3_BLT, F3_BLTU:   t = less;
      F3_BGE, F3_BGEU:   t = !less;
      default:           t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_ctrl_bht.sv
// ---------------------------------------------------------------------------
// branch_bht
// Table of 2-bit saturating direction counters.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset (all counters -> 01)
//   rd_idx / rd_taken - combinational read: MSB of the addressed counter
//   wr_en, wr_idx,
//   wr_taken          - synchronous update: +1 if taken, -1 if not, saturating
// A read of the index being written returns the value before the update.
// ---------------------------------------------------------------------------
module branch_bht
  import branch_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];
  logic [1:0] cur;

  assign rd_taken = ctr_q[rd_idx][1];

  always_comb begin
    ctr_d = ctr_q;
    cur   = ctr_q[wr_idx];
    if (wr_en) begin
      if (wr_taken) begin
        ctr_d[wr_idx] = (cur == 2'b11) ? 2'b11 : cur + 2'd1;
      end else begin
        ctr_d[wr_idx] = (cur == 2'b00) ? 2'b00 : cur - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= CTR_RESET;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
// Resolves branches/jumps in EX, detects mispredictions against the
// prediction carried down the pipe, issues a registered redirect + flush,
// and trains a bimodal predictor that IF queries combinationally.
// Optional feature macro: BRANCH_STATS_EN (adds stat_branches /
// stat_mispredicts saturating counters).
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   if_pc / if_pred_taken   - fetch-side prediction lookup
//   ex_*                    - EX-stage instruction description
//   br_unsign               - comparator mode for the EX operands
//   br_less, br_equal       - comparator results
//   redirect_valid/_pc,
//   flush                   - one-cycle redirect request after a mispredict
// After a mispredict the FSM spends one cycle in SHADOW, ignoring the
// wrong-path instruction that is already in EX.
// ---------------------------------------------------------------------------
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int BHT_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  output logic        br_unsign,
  input  logic        br_less,
  input  logic        br_equal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  state_e      state_q, state_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic        flush_q, flush_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic taken;
  logic resolving;
  logic mispredict;
  logic bht_wr_en;

  // Only the index bits of the fetch PC address the table.
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  assign br_unsign = ex_funct3[1];

  always_comb begin
    taken      = ex_is_jump ? 1'b1 : branch_taken(ex_funct3, br_less, br_equal);
    resolving  = ex_valid && (ex_is_branch || ex_is_jump) && (state_q == ST_RUN);
    mispredict = resolving && (taken != ex_pred_taken);
    bht_wr_en  = resolving && ex_is_branch && !ex_is_jump;
  end

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = mispredict;
    flush_d          = mispredict;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      ST_RUN:    state_d = mispredict ? ST_SHADOW : ST_RUN;
      ST_SHADOW: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
    if (mispredict) begin
      redirect_pc_d = taken ? ex_target : ex_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush          = flush_q;
  assign redirect_pc    = redirect_pc_q;

  branch_bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_taken (if_pred_taken),
    .wr_en    (bht_wr_en),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (taken)
  );

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (resolving && stat_branches_q != 32'hFFFF_FFFF) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (mispredict && stat_mispredicts_q != 32'hFFFF_FFFF) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_ctrl
// Directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a behavioural model of the branch unit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_ctrl;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        br_unsign;
  logic        br_less;
  logic        br_equal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_ctrl #(.BHT_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jump     (ex_is_jump),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .br_unsign      (br_unsign),
    .br_less        (br_less),
    .br_equal       (br_equal),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // ---------------- behavioural model ----------------
  int          m_ctr [DEPTH];
  bit          m_shadow = 0;
  bit          m_rv = 0;
  logic [31:0] m_pc = 0;
  longint      m_nb = 0;
  longint      m_nm = 0;

  function automatic bit ref_taken(input logic [2:0] f3, input logic lt, input logic eq);
    int code;
    code = int'(f3);
    if (code == 0) return eq;
    if (code == 1) return !eq;
    if (code == 4 || code == 6) return lt;
    if (code == 5 || code == 7) return !lt;
    return 0;
  endfunction

  task automatic model_step();
    bit tk, res, mis;
    int ix;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
      m_shadow = 0;
      m_rv     = 0;
      m_pc     = 0;
      m_nb     = 0;
      m_nm     = 0;
    end else begin
      tk  = ex_is_jump ? 1'b1 : ref_taken(ex_funct3, br_less, br_equal);
      res = ex_valid && (ex_is_branch || ex_is_jump) && !m_shadow;
      mis = res && (tk != ex_pred_taken);
      if (res && ex_is_branch && !ex_is_jump) begin
        ix = int'(ex_pc[5:2]);
        if (tk) m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
        else    m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
      end
      m_rv = mis;
      if (mis) m_pc = tk ? ex_target : ex_pc + 32'd4;
      m_shadow = mis;
      if (res && m_nb < 64'hFFFF_FFFF) m_nb++;
      if (mis && m_nm < 64'hFFFF_FFFF) m_nm++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
      check("flush", {31'd0, flush}, {31'd0, m_rv});
      check("redirect_pc", redirect_pc, m_pc);
      check("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, m_ctr[int'(if_pc[5:2])] >= 2});
      check("br_unsign", {31'd0, br_unsign}, {31'd0, ex_funct3[1]});
`ifdef BRANCH_STATS_EN
      check("stat_branches", stat_branches, m_nb[31:0]);
      check("stat_mispredicts", stat_mispredicts, m_nm[31:0]);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid      = 0;
    ex_is_branch  = 0;
    ex_is_jump    = 0;
    ex_pred_taken = 0;
  endtask

  task automatic drive_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pred, input logic lt, input logic eq);
    ex_valid      = 1;
    ex_is_branch  = 1;
    ex_is_jump    = 0;
    ex_funct3     = f3;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pred;
    br_less       = lt;
    br_equal      = eq;
    $display("txn: branch f3=%b pc=%h tgt=%h pred=%0d lt=%0d eq=%0d", f3, pc, tgt, pred, lt, eq);
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    rst_n = 0; if_pc = 0; ex_funct3 = 0; ex_pc = 0; ex_target = 0;
    br_less = 0; br_equal = 0;
    idle();
    repeat (3) step();
    rst_n  = 1;
    chk_en = 1;

    // Reset: every index predicts not-taken, no redirect.
    for (int i = 0; i < DEPTH; i++) begin
      step();
      if_pc = 32'(i) << 2;
      @(negedge clk);
      lit("reset_pred", {31'd0, if_pred_taken}, 32'd0);
    end
    lit("reset_rv", {31'd0, redirect_valid}, 32'd0);
    lit("reset_rpc", redirect_pc, 32'd0);

    // BEQ taken, predicted not-taken.
    step(); drive_br(3'b000, 32'h100, 32'h180, 0, 0, 1);
    step(); idle(); if_pc = 32'h100;
    @(negedge clk);
    lit("beq_rv", {31'd0, redirect_valid}, 32'd1);
    lit("beq_flush", {31'd0, flush}, 32'd1);
    lit("beq_rpc", redirect_pc, 32'h180);
    lit("beq_ctr10", {31'd0, if_pred_taken}, 32'd1);
    step();
    @(negedge clk);
    lit("beq_rv_drop", {31'd0, redirect_valid}, 32'd0);

    // BLTU comparator mode, then BGE not-taken mispredict.
    step(); drive_br(3'b110, 32'h104, 32'h200, 0, 0, 0); ex_valid = 0;
    @(negedge clk);
    lit("bltu_unsign", {31'd0, br_unsign}, 32'd1);
    step(); drive_br(3'b101, 32'h104, 32'h200, 1, 1, 0);
    step(); idle();
    @(negedge clk);
    lit("bge_rv", {31'd0, redirect_valid}, 32'd1);
    lit("bge_rpc", redirect_pc, 32'h108);

    // Back-to-back mispredicts: the second lands in SHADOW.
    step(); drive_br(3'b000, 32'h40, 32'h500, 1, 0, 0);
    step(); drive_br(3'b000, 32'h20, 32'h300, 0, 0, 1);
    @(negedge clk);
    lit("shadow_first_rv", {31'd0, redirect_valid}, 32'd1);
    lit("shadow_first_rpc", redirect_pc, 32'h44);
    step(); idle(); if_pc = 32'h20;
    @(negedge clk);
    lit("shadow_second_rv", {31'd0, redirect_valid}, 32'd0);
    lit("shadow_hold_rpc", redirect_pc, 32'h44);
    lit("shadow_no_train", {31'd0, if_pred_taken}, 32'd0);

    // Saturation at 11: five taken, then two not-taken walk 11->10->01.
    for (int i = 0; i < 5; i++) begin
      step(); drive_br(3'b000, 32'h10, 32'h80, 1, 0, 1);
    end
    step(); drive_br(3'b000, 32'h10, 32'h80, 0, 0, 0);
    step(); idle(); if_pc = 32'h10;
    @(negedge clk);
    lit("sat_after_one_dec", {31'd0, if_pred_taken}, 32'd1);
    step(); drive_br(3'b000, 32'h10, 32'h80, 0, 0, 0);
    step(); idle();
    @(negedge clk);
    lit("sat_after_two_dec", {31'd0, if_pred_taken}, 32'd0);

    // PC+4 wrap.
    step(); drive_br(3'b000, 32'hFFFF_FFFC, 32'h80, 1, 0, 0);
    step(); idle();
    @(negedge clk);
    lit("wrap_rpc", redirect_pc, 32'h0);

    // Reset while a redirect is showing.
    step(); drive_br(3'b000, 32'h100, 32'h180, 0, 0, 1);
    step(); idle(); rst_n = 0;
    @(negedge clk);
    lit("rst_mid_rv_before", {31'd0, redirect_valid}, 32'd1);
    step(); rst_n = 1;
    @(negedge clk);
    lit("rst_mid_rv", {31'd0, redirect_valid}, 32'd0);
    lit("rst_mid_flush", {31'd0, flush}, 32'd0);
    lit("rst_mid_rpc", redirect_pc, 32'd0);

`ifdef BRANCH_STATS_EN
    for (int i = 0; i < 3; i++) begin
      step(); drive_br(3'b000, 32'h30, 32'h90, 1, 0, 1);
    end
    step(); ex_valid = 1; ex_is_branch = 0; ex_is_jump = 1; ex_pred_taken = 0;
    ex_pc = 32'h34; ex_target = 32'h400;
    $display("txn: jal pc=%h tgt=%h pred=0", ex_pc, ex_target);
    step(); idle();
    @(negedge clk);
    lit("stat_br_4", stat_branches, 32'd4);
    lit("stat_mis_1", stat_mispredicts, 32'd1);
    step(); rst_n = 0;
    step(); rst_n = 1;
    @(negedge clk);
    lit("stat_br_rst", stat_branches, 32'd0);
    lit("stat_mis_rst", stat_mispredicts, 32'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n         = ($urandom_range(0, 199) != 0);
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_is_branch  = ($urandom_range(0, 2) != 0);
      ex_is_jump    = ($urandom_range(0, 5) == 0);
      ex_funct3     = 3'($urandom_range(0, 7));
      ex_pc         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      ex_target     = $urandom();
      br_less       = 1'($urandom_range(0, 1));
      br_equal      = 1'($urandom_range(0, 1));
      ex_pred_taken = ($urandom_range(0, 1) != 0) ? (m_ctr[int'(ex_pc[5:2])] >= 2)
                                                  : 1'($urandom_range(0, 1));
      if_pc         = ($urandom_range(0, 3) == 0) ? ex_pc : $urandom();
    end
    step(); idle(); rst_n = 1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
